// File: rtl/rv32_pkg.sv
// Shared types, opcodes and datapath select encodings for the RV32I multicycle controller.
// ILLEGAL_TRAP_EN adds the TRAP state used for unlisted opcodes.
package rv32_pkg;

  localparam int unsigned OP_W = 7;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_JLINK,
    S_LUI
`ifdef ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } mc_state_t;

  localparam logic [OP_W-1:0] OP_LOAD  = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE = 7'b0100011;
  localparam logic [OP_W-1:0] OP_R     = 7'b0110011;
  localparam logic [OP_W-1:0] OP_B     = 7'b1100011;
  localparam logic [OP_W-1:0] OP_I     = 7'b0010011;
  localparam logic [OP_W-1:0] OP_JALR  = 7'b1100111;
  localparam logic [OP_W-1:0] OP_JAL   = 7'b1101111;
  localparam logic [OP_W-1:0] OP_AUIPC = 7'b0010111;
  localparam logic [OP_W-1:0] OP_LUI   = 7'b0110111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_BR   = 2'b01;
  localparam logic [1:0] ALUOP_FN   = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    case (op)
      OP_LOAD, OP_STORE, OP_R, OP_B, OP_I,
      OP_JALR, OP_JAL, OP_AUIPC, OP_LUI: is_legal_op = 1'b1;
      default:                           is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_immsel.sv
// Opcode to immediate-format lookup; purely combinational and state independent.
module mc_immsel
  import rv32_pkg::*;
(
  input  logic [OP_W-1:0] op_i,
  output logic [2:0]      imm_src_o
);

  always_comb begin
    imm_src_o = IMM_I;
    case (op_i)
      OP_STORE:          imm_src_o = IMM_S;
      OP_B:              imm_src_o = IMM_B;
      OP_JAL:            imm_src_o = IMM_J;
      OP_AUIPC, OP_LUI:  imm_src_o = IMM_U;
      default:           imm_src_o = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM with request/ready memory handshake.
// Define ILLEGAL_TRAP_EN to trap unlisted opcodes and raise a sticky illegal flag.
module multicycle_ctrl
  import rv32_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic [OP_W-1:0] op,
  input  logic            branch_taken,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            MemWrite,
  output logic            AdrSrc,
  output logic            IRWrite,
  output logic            PCWrite,
  output logic            RegWrite,
  output logic [1:0]      ResultSrc,
  output logic [1:0]      ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ALUOp,
  output logic [2:0]      ImmSrc,
  output logic            instr_done,
  output logic            illegal
);

  mc_state_t state_q, state_d;

  mc_immsel u_immsel (
    .op_i      (op),
    .imm_src_o (ImmSrc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  always_comb begin
    illegal_d = illegal_q;
    if (state_q == S_DECODE && !is_legal_op(op)) illegal_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) illegal_q <= 1'b0;
    else          illegal_q <= illegal_d;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_B:              state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_AUIPC:          state_d = S_ALUWB;
          OP_LUI:            state_d = S_LUI;
`ifdef ILLEGAL_TRAP_EN
          default:           state_d = S_TRAP;
`else
          default:           state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR,
      S_EXECI,
      S_JAL:      state_d = S_ALUWB;
      S_JALR:     state_d = S_JLINK;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:     state_d = S_TRAP;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  // Per-state datapath controls; strobes are masked while reset is held.
  always_comb begin
    mem_req    = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    instr_done = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RD2;
    ALUOp      = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
`ifndef ILLEGAL_TRAP_EN
        instr_done = !is_legal_op(op);
`endif
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        mem_req = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        mem_req    = 1'b1;
        MemWrite   = 1'b1;
        instr_done = mem_ready;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RD1;
        ALUOp   = ALUOP_FN;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FN;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = SRCA_RD1;
        ALUOp      = ALUOP_BR;
        PCWrite    = branch_taken;
        instr_done = 1'b1;
      end
      S_JAL: begin
        PCWrite = 1'b1;
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
      end
      S_JALR: begin
        ALUSrcA   = SRCA_RD1;
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURES;
        PCWrite   = 1'b1;
      end
      S_JLINK: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALURES;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_LUI: begin
        ResultSrc  = RES_IMM;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    if (!reset_n) begin
      mem_req    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      RegWrite   = 1'b0;
      instr_done = 1'b0;
    end
  end

endmodule
